// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
package multdiv_pkg;
    localparam int WIDTH = 32;
    localparam int ITER = 32;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;
endpackage

// File: rtl/multdiv_booth_step.sv
// One radix-2 Booth iteration over the {acc, q, q-1} register.
module booth_step
    import multdiv_pkg::*;
(
    input  logic [2*WIDTH:0] cur,
    input  logic [WIDTH-1:0] m,
    output logic [2*WIDTH:0] nxt
);
    logic [WIDTH:0] acc_ext;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    // One guard bit keeps the true sign when m is INT_MIN.
    always_comb begin
        acc_ext = {cur[2*WIDTH], cur[2*WIDTH:WIDTH+1]};
        m_ext = {m[WIDTH-1], m};
        unique case (cur[1:0])
            2'b01: sum = acc_ext + m_ext;
            2'b10: sum = acc_ext - m_ext;
            default: sum = acc_ext;
        endcase
        nxt = {sum, cur[WIDTH:1]};
    end
endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit multiply (Booth) / divide (restoring) unit.
module multdiv
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t state;
    state_t nstate;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic q1;
    logic [WIDTH-1:0] m;
    logic is_div;
    logic neg;
    logic ovf;

    logic start;
    logic last;
    logic [2*WIDTH:0] booth_nxt;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0] prod_hi;
    logic [WIDTH-1:0] fin_result;
    logic fin_exc;

    assign start = ctrl_MULT | ctrl_DIV;
    assign last = (cnt == CNT_W'(ITER - 1));
    assign busy = (state != IDLE);

    booth_step u_booth (
        .cur(({acc, q, q1})),
        .m  (m),
        .nxt(booth_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (start) begin
            nstate = ctrl_MULT ? MUL : DIV;
        end else begin
            unique case (state)
                IDLE: nstate = IDLE;
                MUL, DIV: nstate = last ? DONE : state;
                DONE: nstate = IDLE;
                default: nstate = IDLE;
            endcase
        end
    end

    // Restoring step on magnitudes: remainder in acc, quotient shifts into q.
    always_comb begin
        a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        shifted = {acc, q[WIDTH-1]};
        diff = shifted - {1'b0, m};
        if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            q_d = {q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = shifted[WIDTH-1:0];
            q_d = {q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_hi = {acc, q[WIDTH-1]};
        fin_result = q;
        fin_exc = !((&prod_hi) || (~|prod_hi));
        if (is_div) begin
            if (m == '0) begin
                fin_result = '0;
                fin_exc = 1'b1;
            end else if (ovf) begin
                fin_result = INT_MIN;
                fin_exc = 1'b1;
            end else begin
                fin_result = neg ? -q : q;
                fin_exc = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_result <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            cnt <= '0;
            acc <= '0;
            q <= '0;
            q1 <= 1'b0;
            m <= '0;
            is_div <= 1'b0;
            neg <= 1'b0;
            ovf <= 1'b0;
        end else begin
            data_resultRDY <= (state == DONE);
            if (state == DONE) begin
                data_result <= fin_result;
                data_exception <= fin_exc;
            end
            if (start) begin
                cnt <= '0;
                acc <= '0;
                q1 <= 1'b0;
                is_div <= !ctrl_MULT;
                if (ctrl_MULT) begin
                    q <= data_operandB;
                    m <= data_operandA;
                end else begin
                    q <= a_mag;
                    m <= b_mag;
                    neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    ovf <= (data_operandA == INT_MIN) && (&data_operandB);
                end
            end else if (state == MUL) begin
                {acc, q, q1} <= booth_nxt;
                cnt <= cnt + 1'b1;
            end else if (state == DIV) begin
                acc <= acc_d;
                q <= q_d;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
